// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/interrupt controller: FSM state encoding,
// holdoff counter width, NOP encoding and ID/EX control bundle field widths.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        StRun       = 2'd0,
        StIrqEnter  = 2'd1,
        StIrqActive = 2'd2,
        StHoldoff   = 2'd3
    } ctrl_state_e;

    // Wide enough for the largest holdoff reload value (15 - 1)
    localparam int unsigned HOLDOFF_CNT_W = 4;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    localparam int unsigned IDEX_WB_W     = 2;
    localparam int unsigned IDEX_MEM_W    = 2;
    localparam int unsigned IDEX_EX_W     = 4;
    localparam int unsigned IDEX_ALU_OP_W = 4;

    typedef struct packed {
        logic [IDEX_WB_W-1:0]     wb;
        logic [IDEX_MEM_W-1:0]    mem;
        logic [IDEX_EX_W-1:0]     ex;
        logic [IDEX_ALU_OP_W-1:0] alu_op;
    } idex_ctrl_t;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard comparator between the EX load destination and the
// source registers of the instruction in ID. Register 0 never creates a hazard.
module load_use_detect #(
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  i_id_valid,
    input  logic [REG_ADDR_W-1:0] i_id_rs,
    input  logic [REG_ADDR_W-1:0] i_id_rt,
    input  logic                  i_id_uses_rt,
    input  logic                  i_ex_mem_read,
    input  logic [REG_ADDR_W-1:0] i_ex_rt,
    output logic                  o_lu
);

    logic w_rs_match;
    logic w_rt_match;

    assign w_rs_match = (i_ex_rt == i_id_rs);
    assign w_rt_match = i_id_uses_rt & (i_ex_rt == i_id_rt);

    assign o_lu = i_ex_mem_read & (i_ex_rt != '0) & i_id_valid & (w_rs_match | w_rt_match);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/interrupt sequencer for the 5-stage pipeline. Define PIPELINE_HAZARD_STATS_EN
// to add saturating stall/flush/IRQ statistics counters.
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned HOLDOFF    = 2,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                  sysclk,
    input  logic                  reset,
    input  logic                  ID_Valid,
    input  logic [REG_ADDR_W-1:0] ID_Rs,
    input  logic [REG_ADDR_W-1:0] ID_Rt,
    input  logic                  ID_UsesRt,
    input  logic                  ID_Jump,
    input  logic                  ID_Eret,
    input  logic                  EX_MemRead,
    input  logic [REG_ADDR_W-1:0] EX_Rt,
    input  logic                  EX_BranchTaken,
    input  logic                  IRQ,
    input  logic                  IRQ_Enable,
    output logic                  PC_Write,
    output logic                  IF_ID_Write,
    output logic                  IF_Flush,
    output logic                  ID_Flush,
    output logic                  ID_IRQ,
    output logic                  IRQ_Ack,
`ifdef PIPELINE_HAZARD_STATS_EN
    output logic [CNT_W-1:0]      Stall_Cnt,
    output logic [CNT_W-1:0]      Flush_Cnt,
    output logic [CNT_W-1:0]      Irq_Cnt,
`endif
    output logic [1:0]            Ctrl_State
);

    ctrl_state_e              r_state;
    ctrl_state_e              w_state_d;
    logic [HOLDOFF_CNT_W-1:0] r_hold_cnt;
    logic [HOLDOFF_CNT_W-1:0] w_hold_cnt_d;
    logic                     w_lu;
    logic                     w_take;
    logic                     w_eret_go;

    load_use_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_load_use_detect (
        .i_id_valid    (ID_Valid),
        .i_id_rs       (ID_Rs),
        .i_id_rt       (ID_Rt),
        .i_id_uses_rt  (ID_UsesRt),
        .i_ex_mem_read (EX_MemRead),
        .i_ex_rt       (EX_Rt),
        .o_lu          (w_lu)
    );

    assign w_take    = (r_state == StRun) & IRQ & IRQ_Enable & ID_Valid & ~EX_BranchTaken & ~w_lu;
    assign w_eret_go = ID_Eret & ID_Valid & ~w_lu & ~EX_BranchTaken;

    always_comb begin
        w_state_d    = r_state;
        w_hold_cnt_d = r_hold_cnt;
        unique case (r_state)
            StRun: begin
                if (w_take) w_state_d = StIrqEnter;
            end
            StIrqEnter: begin
                w_state_d = EX_BranchTaken ? StRun : StIrqActive;
            end
            StIrqActive: begin
                if (w_eret_go) begin
                    w_state_d    = StHoldoff;
                    w_hold_cnt_d = HOLDOFF_CNT_W'(HOLDOFF - 1);
                end
            end
            StHoldoff: begin
                if (r_hold_cnt == '0) w_state_d = StRun;
                else                  w_hold_cnt_d = r_hold_cnt - 1'b1;
            end
        endcase
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_state    <= StRun;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_d;
            r_hold_cnt <= w_hold_cnt_d;
        end
    end

    // Reset forces a flushing, non-advancing pipeline independent of the clock
    always_comb begin
        PC_Write    = 1'b1;
        IF_ID_Write = 1'b1;
        IF_Flush    = 1'b0;
        ID_Flush    = 1'b0;
        ID_IRQ      = 1'b0;
        IRQ_Ack     = 1'b0;
        if (reset) begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            IF_Flush    = 1'b1;
            ID_Flush    = 1'b1;
        end else if (EX_BranchTaken) begin
            IF_Flush = 1'b1;
            ID_Flush = 1'b1;
        end else if (r_state == StIrqEnter) begin
            ID_IRQ   = 1'b1;
            IRQ_Ack  = 1'b1;
            IF_Flush = 1'b1;
        end else if (w_lu) begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            ID_Flush    = 1'b1;
        end else if (ID_Jump) begin
            IF_Flush = 1'b1;
        end
    end

    assign Ctrl_State = r_state;

`ifdef PIPELINE_HAZARD_STATS_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic [CNT_W-1:0] r_irq_cnt;

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
            r_irq_cnt   <= '0;
        end else begin
            if (w_lu && (r_stall_cnt != '1))     r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (IF_Flush && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            if (IRQ_Ack && (r_irq_cnt != '1))    r_irq_cnt   <= r_irq_cnt + CNT_W'(1);
        end
    end

    assign Stall_Cnt = r_stall_cnt;
    assign Flush_Cnt = r_flush_cnt;
    assign Irq_Cnt   = r_irq_cnt;
`else
    logic [CNT_W-1:0] w_unused_cnt;
    assign w_unused_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: each directed vector pushes its hand-computed
// output word; a monitor pops and compares on the falling edge.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned RW = 5;

    logic          sysclk = 1'b0;
    logic          reset;
    logic          ID_Valid, ID_UsesRt, ID_Jump, ID_Eret;
    logic [RW-1:0] ID_Rs, ID_Rt, EX_Rt;
    logic          EX_MemRead, EX_BranchTaken, IRQ, IRQ_Enable;
    logic          PC_Write, IF_ID_Write, IF_Flush, ID_Flush, ID_IRQ, IRQ_Ack;
    logic [1:0]    Ctrl_State;
`ifdef PIPELINE_HAZARD_STATS_EN
    logic [31:0]   Stall_Cnt, Flush_Cnt, Irq_Cnt;
`endif

    // Expected word: {PC_Write, IF_ID_Write, IF_Flush, ID_Flush, ID_IRQ, IRQ_Ack, Ctrl_State}
    localparam logic [7:0] E_RST    = 8'b0011_0000;
    localparam logic [7:0] E_RUN    = 8'b1100_0000;
    localparam logic [7:0] E_STALL  = 8'b0001_0000;
    localparam logic [7:0] E_BR     = 8'b1111_0000;
    localparam logic [7:0] E_JUMP   = 8'b1110_0000;
    localparam logic [7:0] E_ENTER  = 8'b1110_1101;
    localparam logic [7:0] E_ACT    = 8'b1100_0010;
    localparam logic [7:0] E_ACT_LU = 8'b0001_0010;
    localparam logic [7:0] E_HOLD   = 8'b1100_0011;
    localparam logic [7:0] E_BR_ENT = 8'b1111_0001;

    typedef struct {
        string      name;
        logic [7:0] exp;
    } sb_item_t;

    sb_item_t sb_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    pipeline_hazard_ctrl #(
        .REG_ADDR_W (RW),
        .HOLDOFF    (2),
        .CNT_W      (32)
    ) dut (
        .sysclk         (sysclk),
        .reset          (reset),
        .ID_Valid       (ID_Valid),
        .ID_Rs          (ID_Rs),
        .ID_Rt          (ID_Rt),
        .ID_UsesRt      (ID_UsesRt),
        .ID_Jump        (ID_Jump),
        .ID_Eret        (ID_Eret),
        .EX_MemRead     (EX_MemRead),
        .EX_Rt          (EX_Rt),
        .EX_BranchTaken (EX_BranchTaken),
        .IRQ            (IRQ),
        .IRQ_Enable     (IRQ_Enable),
        .PC_Write       (PC_Write),
        .IF_ID_Write    (IF_ID_Write),
        .IF_Flush       (IF_Flush),
        .ID_Flush       (ID_Flush),
        .ID_IRQ         (ID_IRQ),
        .IRQ_Ack        (IRQ_Ack),
`ifdef PIPELINE_HAZARD_STATS_EN
        .Stall_Cnt      (Stall_Cnt),
        .Flush_Cnt      (Flush_Cnt),
        .Irq_Cnt        (Irq_Cnt),
`endif
        .Ctrl_State     (Ctrl_State)
    );

    always #5 sysclk = ~sysclk;

    // Monitor: outputs are combinational, so every cycle with a pending entry presents one
    always @(negedge sysclk) begin
        if (sb_q.size() != 0) begin
            sb_item_t   it;
            logic [7:0] act;
            it  = sb_q.pop_front();
            act = {PC_Write, IF_ID_Write, IF_Flush, ID_Flush, ID_IRQ, IRQ_Ack, Ctrl_State};
            n_cmp++;
            if (act !== it.exp) begin
                n_bad++;
                $display("FAIL %s: got %b, expected %b", it.name, act, it.exp);
            end
        end
    end

    task automatic step(input string name, input logic rst, input logic vld,
                        input logic [RW-1:0] rs, input logic [RW-1:0] rt, input logic uses_rt,
                        input logic jmp, input logic eret, input logic mrd,
                        input logic [RW-1:0] ex_rt, input logic br, input logic irq,
                        input logic irq_en, input logic [7:0] exp);
        @(posedge sysclk);
        #1;
        reset = rst; ID_Valid = vld; ID_Rs = rs; ID_Rt = rt; ID_UsesRt = uses_rt;
        ID_Jump = jmp; ID_Eret = eret; EX_MemRead = mrd; EX_Rt = ex_rt;
        EX_BranchTaken = br; IRQ = irq; IRQ_Enable = irq_en;
        sb_q.push_back('{name, exp});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; ID_Valid = 1'b0; ID_Rs = '0; ID_Rt = '0; ID_UsesRt = 1'b0;
        ID_Jump = 1'b0; ID_Eret = 1'b0; EX_MemRead = 1'b0; EX_Rt = '0;
        EX_BranchTaken = 1'b0; IRQ = 1'b0; IRQ_Enable = 1'b0;

        //    name                  rst vld rs rt ur jmp er mrd ex br irq en  expected
        step("reset_a",             1, 0,  0, 0, 0, 0,  0, 0,  0, 0, 0,  0, E_RST);
        step("reset_b",             1, 1,  8, 1, 1, 0,  0, 1,  8, 0, 1,  1, E_RST);
        step("idle",                0, 1,  1, 2, 1, 0,  0, 0,  0, 0, 0,  0, E_RUN);
        step("lu_rs",               0, 1,  8, 1, 1, 0,  0, 1,  8, 0, 0,  0, E_STALL);
        step("after_stall",         0, 1,  8, 1, 1, 0,  0, 0,  0, 0, 0,  0, E_RUN);
        step("lu_rt",               0, 1,  3, 9, 1, 0,  0, 1,  9, 0, 0,  0, E_STALL);
        step("lu_rt_back_to_back",  0, 1,  9, 4, 1, 0,  0, 1,  9, 0, 0,  1, E_STALL);
        step("rt_not_used",         0, 1,  3, 9, 0, 0,  0, 1,  9, 0, 0,  0, E_RUN);
        step("bubble_in_id",        0, 0,  9, 9, 1, 0,  0, 1,  9, 0, 0,  0, E_RUN);
        step("zero_reg",            0, 1,  0, 1, 1, 0,  0, 1,  0, 0, 0,  0, E_RUN);
        step("branch_over_lu",      0, 1,  8, 1, 1, 0,  0, 1,  8, 1, 0,  0, E_BR);
        step("jump",                0, 1,  1, 2, 1, 1,  0, 0,  0, 0, 0,  0, E_JUMP);
        step("lu_over_jump",        0, 1,  8, 2, 1, 1,  0, 1,  8, 0, 0,  0, E_STALL);
        step("irq_masked",          0, 1,  1, 2, 1, 0,  0, 0,  0, 0, 1,  0, E_RUN);
        step("irq_masked_next",     0, 1,  1, 2, 1, 0,  0, 0,  0, 0, 0,  0, E_RUN);
        step("branch_blocks_take",  0, 1,  1, 2, 1, 0,  0, 0,  0, 1, 1,  1, E_BR);
        step("no_take_after_br",    0, 1,  1, 2, 1, 0,  0, 0,  0, 0, 0,  1, E_RUN);
        step("irq_during_lu",       0, 1,  8, 1, 1, 0,  0, 1,  8, 0, 1,  1, E_STALL);
        step("irq_take",            0, 1,  8, 1, 1, 0,  0, 0,  0, 0, 1,  1, E_RUN);
        step("irq_enter",           0, 1,  1, 2, 1, 0,  0, 0,  0, 0, 1,  1, E_ENTER);
        step("irq_active",          0, 1,  1, 2, 1, 0,  0, 0,  0, 0, 1,  1, E_ACT);
        step("no_second_ack",       0, 1,  1, 2, 1, 0,  0, 0,  0, 0, 1,  1, E_ACT);
        step("lu_in_active",        0, 1,  5, 2, 1, 0,  0, 1,  5, 0, 1,  1, E_ACT_LU);
        step("eret_blocked_by_lu",  0, 1,  5, 2, 1, 0,  1, 1,  5, 0, 1,  1, E_ACT_LU);
        step("eret",                0, 1, 26, 0, 0, 0,  1, 0,  0, 0, 1,  1, E_ACT);
        step("holdoff_1",           0, 1,  1, 2, 1, 0,  0, 0,  0, 0, 1,  1, E_HOLD);
        step("holdoff_2",           0, 1,  1, 2, 1, 0,  0, 0,  0, 0, 1,  1, E_HOLD);
        step("run_again",           0, 1,  1, 2, 1, 0,  0, 0,  0, 0, 1,  1, E_RUN);
        step("irq_enter_2",         0, 1,  1, 2, 1, 0,  0, 0,  0, 0, 1,  1, E_ENTER);
        step("irq_active_2",        0, 1,  1, 2, 1, 0,  0, 0,  0, 0, 1,  1, E_ACT);
        step("reset_mid_irq",       1, 1,  1, 2, 1, 0,  0, 0,  0, 0, 1,  1, E_RST);
`ifdef PIPELINE_HAZARD_STATS_EN
        #2;
        n_cmp++;
        if ({Stall_Cnt, Flush_Cnt, Irq_Cnt} !== 96'd0) begin
            n_bad++;
            $display("FAIL stats_cleared: got %0d/%0d/%0d, expected 0/0/0",
                     Stall_Cnt, Flush_Cnt, Irq_Cnt);
        end
`endif
        step("post_reset",          0, 1,  1, 2, 1, 0,  0, 0,  0, 0, 0,  1, E_RUN);
        step("take_3",              0, 1,  1, 2, 1, 0,  0, 0,  0, 0, 1,  1, E_RUN);
        step("branch_in_enter",     0, 1,  1, 2, 1, 0,  0, 0,  0, 1, 1,  1, E_BR_ENT);
        step("branch_cancels_irq",  0, 1,  1, 2, 1, 0,  0, 0,  0, 0, 0,  1, E_RUN);

        for (int i = 0; i < 4 && sb_q.size() != 0; i++) @(negedge sysclk);
        #1;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending entries, expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
